// File: rtl/apb_requester_if.sv
`default_nettype none
// ============================================================================
// Module      : apb_requester_if
// Description : Request/response handshake plus APB3 bus bundle for the
//               apb_requester master stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface apb_requester_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  req_write;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_error;
    logic                  rsp_timeout;

    logic                  PSEL;
    logic                  PENABLE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic                  PWRITE;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic                  PREADY;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PSLVERR;

    modport master (
        input  req_valid, req_addr, req_write, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
        output PSEL, PENABLE, PADDR, PWRITE, PWDATA,
        input  PREADY, PRDATA, PSLVERR
    );

    modport slave (
        output req_valid, req_addr, req_write, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
        input  PSEL, PENABLE, PADDR, PWRITE, PWDATA,
        output PREADY, PRDATA, PSLVERR
    );
endinterface
`default_nettype wire

// File: rtl/apb_requester.sv
`default_nettype none
// ============================================================================
// Module      : apb_requester
// Description : Converts valid/ready requests into APB3 SETUP/ACCESS transfers
//               and returns one registered response per transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_requester #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  wire logic           PCLK,
    input  wire logic           PRESET,
    apb_requester_if.master     bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    localparam bit         c_to_en  = (TIMEOUT != 0);
    localparam logic [8:0] c_to_val = 9'(TIMEOUT);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_req_ready;
    logic                  w_accept;
    logic                  w_done;
    logic                  w_abort;

    logic [7:0]            r_cnt;
    logic                  r_psel;
    logic                  r_penable;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic                  r_pwrite;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_error;
    logic                  r_rsp_timeout;

    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = 1'b0;
        w_done      = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_req_ready = 1'b1;
                if (bus.req_valid) w_state_nxt = S_SETUP;
            end
            S_SETUP: begin
                w_state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                if (bus.PREADY) begin
                    // Completion cycle can accept the next request to chain transfers
                    w_done      = 1'b1;
                    w_req_ready = 1'b1;
                    w_state_nxt = bus.req_valid ? S_SETUP : S_IDLE;
                end else if (c_to_en && (({1'b0, r_cnt} + 9'd1) == c_to_val)) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign w_accept = bus.req_valid & w_req_ready;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state       <= S_IDLE;
            r_cnt         <= 8'd0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_paddr       <= '0;
            r_pwrite      <= 1'b0;
            r_pwdata      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_error   <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_psel    <= (w_state_nxt != S_IDLE);
            r_penable <= (w_state_nxt == S_ACCESS);
            if (w_accept) begin
                r_paddr  <= bus.req_addr;
                r_pwrite <= bus.req_write;
                r_pwdata <= bus.req_wdata;
            end
            if (w_state_nxt == S_SETUP) begin
                r_cnt <= 8'd0;
            end else if ((r_state == S_ACCESS) && !bus.PREADY) begin
                r_cnt <= r_cnt + 8'd1;
            end
            r_rsp_valid <= w_done | w_abort;
            if (w_done) begin
                r_rsp_rdata   <= r_pwrite ? '0 : bus.PRDATA;
                r_rsp_error   <= bus.PSLVERR;
                r_rsp_timeout <= 1'b0;
            end else if (w_abort) begin
                r_rsp_rdata   <= '0;
                r_rsp_error   <= 1'b1;
                r_rsp_timeout <= 1'b1;
            end
        end
    end

    assign bus.req_ready   = w_req_ready;
    assign bus.PSEL        = r_psel;
    assign bus.PENABLE     = r_penable;
    assign bus.PADDR       = r_paddr;
    assign bus.PWRITE      = r_pwrite;
    assign bus.PWDATA      = r_pwdata;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.rsp_error   = r_rsp_error;
    assign bus.rsp_timeout = r_rsp_timeout;

endmodule
`default_nettype wire

// File: tb/tb_apb_requester.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_requester
// Description : Directed-vector scoreboard bench for apb_requester.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_requester;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int TIMEOUT    = 4;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        to;
        int          cyc;
    } exp_t;

    logic PCLK;
    logic PRESET;
    int   cyc;
    int   errors;
    int   checks;
    exp_t sb[$];

    apb_requester_if #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus ();

    apb_requester #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    initial cyc = 0;
    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [31:0] rdata, input logic err, input logic to, input int at);
        exp_t e;
        e.rdata = rdata;
        e.err   = err;
        e.to    = to;
        e.cyc   = at;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [31:0] addr, input logic wr, input logic [31:0] wdata);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_write = wr;
        bus.req_wdata = wdata;
    endtask

    // Monitor: every response pulse must match the oldest expected entry, including its cycle
    always @(negedge PCLK) begin
        if (bus.rsp_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_cycle",   32'(cyc),              32'(e.cyc));
                chk("rsp_rdata",   bus.rsp_rdata,         e.rdata);
                chk("rsp_error",   32'(bus.rsp_error),    32'(e.err));
                chk("rsp_timeout", 32'(bus.rsp_timeout),  32'(e.to));
            end
        end
    end

    initial begin
        errors        = 0;
        checks        = 0;
        PRESET        = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_write = 1'b0;
        bus.req_wdata = '0;
        bus.PREADY    = 1'b1;
        bus.PRDATA    = '0;
        bus.PSLVERR   = 1'b0;

        // Reset, then idle
        repeat (3) @(negedge PCLK);
        PRESET = 1'b0;
        repeat (5) @(negedge PCLK);
        chk("idle_psel",      32'(bus.PSEL),      32'd0);
        chk("idle_penable",   32'(bus.PENABLE),   32'd0);
        chk("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("idle_req_ready", 32'(bus.req_ready), 32'd1);
        chk("idle_paddr",     bus.PADDR,          32'd0);
        chk("idle_rsp_rdata", bus.rsp_rdata,      32'd0);

        // Zero-wait write
        issue(32'h10, 1'b1, 32'hA5A5_A5A5);
        bus.PREADY = 1'b1;
        push(32'h0, 1'b0, 1'b0, cyc + 3);
        @(negedge PCLK);
        bus.req_valid = 1'b0;
        #1;
        chk("wr_setup_psel",    32'(bus.PSEL),      32'd1);
        chk("wr_setup_penable", 32'(bus.PENABLE),   32'd0);
        chk("wr_setup_paddr",   bus.PADDR,          32'h10);
        chk("wr_setup_pwdata",  bus.PWDATA,         32'hA5A5_A5A5);
        chk("wr_setup_pwrite",  32'(bus.PWRITE),    32'd1);
        chk("wr_setup_ready",   32'(bus.req_ready), 32'd0);
        @(negedge PCLK);
        chk("wr_access_psel",    32'(bus.PSEL),      32'd1);
        chk("wr_access_penable", 32'(bus.PENABLE),   32'd1);
        chk("wr_access_paddr",   bus.PADDR,          32'h10);
        chk("wr_access_pwdata",  bus.PWDATA,         32'hA5A5_A5A5);
        chk("wr_access_ready",   32'(bus.req_ready), 32'd1);
        @(negedge PCLK);
        chk("wr_done_psel", 32'(bus.PSEL), 32'd0);
        repeat (2) @(negedge PCLK);

        // Read with three wait states and a slave error
        bus.PREADY  = 1'b0;
        bus.PRDATA  = 32'hDEAD_DEAD;
        issue(32'h20, 1'b0, 32'h0);
        push(32'h1234, 1'b1, 1'b0, cyc + 6);
        @(negedge PCLK);
        bus.req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            #1;
            chk("rd_wait_penable", 32'(bus.PENABLE),   32'd1);
            chk("rd_wait_ready",   32'(bus.req_ready), 32'd0);
            chk("rd_wait_paddr",   bus.PADDR,          32'h20);
        end
        @(negedge PCLK);
        bus.PREADY  = 1'b1;
        bus.PRDATA  = 32'h1234;
        bus.PSLVERR = 1'b1;
        @(negedge PCLK);
        bus.PSLVERR = 1'b0;
        bus.PRDATA  = 32'h0;
        repeat (2) @(negedge PCLK);

        // Back-to-back: write then read
        bus.PREADY = 1'b1;
        bus.PRDATA = 32'h55AA;
        issue(32'h30, 1'b1, 32'h1111_1111);
        push(32'h0, 1'b0, 1'b0, cyc + 3);
        @(negedge PCLK);
        chk("b2b_a_setup_penable", 32'(bus.PENABLE), 32'd0);
        issue(32'h34, 1'b0, 32'h0);
        @(negedge PCLK);
        #1;
        chk("b2b_a_access_penable", 32'(bus.PENABLE),   32'd1);
        chk("b2b_a_access_ready",   32'(bus.req_ready), 32'd1);
        push(32'h55AA, 1'b0, 1'b0, cyc + 3);
        @(negedge PCLK);
        bus.req_valid = 1'b0;
        chk("b2b_b_setup_psel",    32'(bus.PSEL),    32'd1);
        chk("b2b_b_setup_penable", 32'(bus.PENABLE), 32'd0);
        chk("b2b_b_setup_paddr",   bus.PADDR,        32'h34);
        @(negedge PCLK);
        chk("b2b_b_access_penable", 32'(bus.PENABLE), 32'd1);
        @(negedge PCLK);
        chk("b2b_done_psel", 32'(bus.PSEL), 32'd0);
        repeat (2) @(negedge PCLK);

        // Timeout abort after TIMEOUT ACCESS cycles
        bus.PREADY = 1'b0;
        bus.PRDATA = 32'hBEEF;
        issue(32'h40, 1'b0, 32'h0);
        push(32'h0, 1'b1, 1'b1, cyc + 6);
        @(negedge PCLK);
        bus.req_valid = 1'b1;
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge PCLK);
            #1;
            chk("to_access_penable", 32'(bus.PENABLE),   32'd1);
            chk("to_access_ready",   32'(bus.req_ready), 32'd0);
        end
        bus.req_valid = 1'b0;
        @(negedge PCLK);
        chk("to_abort_psel",    32'(bus.PSEL),    32'd0);
        chk("to_abort_penable", 32'(bus.PENABLE), 32'd0);
        bus.PREADY = 1'b1;
        repeat (2) @(negedge PCLK);

        // Reset in the middle of ACCESS, then a fresh read
        bus.PREADY = 1'b0;
        issue(32'h50, 1'b1, 32'h77);
        @(negedge PCLK);
        bus.req_valid = 1'b0;
        @(negedge PCLK);
        chk("rst_pre_penable", 32'(bus.PENABLE), 32'd1);
        PRESET = 1'b1;
        @(negedge PCLK);
        chk("rst_psel",      32'(bus.PSEL),      32'd0);
        chk("rst_penable",   32'(bus.PENABLE),   32'd0);
        chk("rst_paddr",     bus.PADDR,          32'd0);
        chk("rst_pwdata",    bus.PWDATA,         32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        PRESET      = 1'b0;
        bus.PREADY  = 1'b1;
        bus.PRDATA  = 32'hCAFE;
        issue(32'h60, 1'b0, 32'h0);
        #1;
        chk("post_rst_ready", 32'(bus.req_ready), 32'd1);
        push(32'hCAFE, 1'b0, 1'b0, cyc + 3);
        @(negedge PCLK);
        bus.req_valid = 1'b0;
        repeat (4) @(negedge PCLK);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb_requester.md
Name: apb_requester

Overview:
- Upstream APB master stage that drives the PSEL/PENABLE-based peripherals in our designs and their equivalence benches.
- Converts a simple valid/ready request interface into legal APB3 transfers (SETUP -> ACCESS, PREADY wait states).
- Returns one registered response per transfer, carrying read data, slave error and timeout status.

Parameters:
ADDR_WIDTH, 32, width of req_addr/PADDR
DATA_WIDTH, 32, width of write/read data
TIMEOUT, 16, consecutive ACCESS cycles with PREADY=0 before abort; 0 disables timeout (range 0..255)

Ports:
PCLK  input  1  clock, all logic on rising edge
PRESET  input  1  synchronous active-high reset
req_valid  input  1  request present
req_ready  output  1  request accepted when req_valid && req_ready
req_addr  input  ADDR_WIDTH  transfer address
req_write  input  1  1=write, 0=read
req_wdata  input  DATA_WIDTH  write data
rsp_valid  output  1  one-cycle response pulse, no backpressure
rsp_rdata  output  DATA_WIDTH  read data (0 for writes and aborted transfers)
rsp_error  output  1  PSLVERR sampled at completion, or timeout
rsp_timeout  output  1  transfer aborted by timeout
PSEL  output  1  APB select
PENABLE  output  1  APB enable
PADDR  output  ADDR_WIDTH  APB address
PWRITE  output  1  APB direction
PWDATA  output  DATA_WIDTH  APB write data
PREADY  input  1  slave ready
PRDATA  input  DATA_WIDTH  slave read data
PSLVERR  input  1  slave error

Behaviour:
- Reset (PRESET=1 at a PCLK edge) forces: state IDLE; PSEL, PENABLE, PWRITE, rsp_valid, rsp_error, rsp_timeout = 0; PADDR, PWDATA, rsp_rdata = 0; timeout counter = 0.
- Reset applied mid-transfer abandons the transfer. No response is generated.
- All APB and rsp outputs are registered. req_ready is combinational from state and PREADY.
- FSM has three states: IDLE, SETUP, ACCESS.
- IDLE:
  - req_ready=1.
  - On accept: latch addr/write/wdata into PADDR/PWRITE/PWDATA; next state SETUP.
- SETUP:
  - PSEL=1, PENABLE=0, req_ready=0.
  - Always -> ACCESS next cycle.
- ACCESS:
  - PSEL=1, PENABLE=1.
  - PADDR, PWRITE, PWDATA are held stable from SETUP through completion.
- ACCESS with PREADY=1 (completion):
  - Next cycle: rsp_valid=1; rsp_error=PSLVERR; rsp_timeout=0.
  - rsp_rdata=PRDATA if read, else 0.
  - req_ready=1 in the completion cycle. If a request is accepted: latch it and go to SETUP (PSEL stays 1, PENABLE drops to 0). Otherwise go to IDLE (PSEL=0).
- ACCESS with PREADY=0:
  - Counter increments.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT: next cycle PSEL=0, PENABLE=0, state IDLE.
  - The abort produces rsp_valid=1, rsp_error=1, rsp_timeout=1, rsp_rdata=0.
  - req_ready=0 on the abort cycle.
- The counter clears on entry to SETUP.
- Latency: accept at cycle N -> SETUP N+1 -> ACCESS N+2 -> rsp_valid at N+3 with zero wait states; each wait state adds 1 cycle.
- Back-to-back throughput is one transfer per 2 cycles.
- rsp_valid is high for exactly one cycle per transfer. rsp_* hold their last values while rsp_valid=0.
- PRDATA and PSLVERR are sampled only when PENABLE && PREADY.

Test Plan:
- Reset then idle 5 cycles -> PSEL=PENABLE=rsp_valid=0, req_ready=1.
- Write addr=0x10, wdata=0xA5A5A5A5, PREADY tied 1 -> SETUP at N+1, ACCESS at N+2; PADDR/PWDATA stable both cycles; rsp_valid at N+3 with rsp_error=0, rsp_rdata=0.
- Read addr=0x20, PREADY low for 3 ACCESS cycles then high with PRDATA=0x1234, PSLVERR=1 -> rsp_valid 6 cycles after accept, rsp_rdata=0x1234, rsp_error=1, rsp_timeout=0.
- Two requests presented back-to-back -> PSEL remains 1 between transfers; PENABLE pattern 0,1,0,1; two rsp_valid pulses 2 cycles apart.
- TIMEOUT=4, PREADY held 0 -> abort after 4 ACCESS cycles; PSEL=0 next cycle; rsp_error=1, rsp_timeout=1; req_ready=0 on the abort cycle.
- PRESET asserted during ACCESS -> next cycle all outputs at reset values, no rsp_valid; a fresh request afterwards completes normally.
